// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add bit per clock, LSB first, carry held in a flop.
// Start/busy/done handshake; sum/cout update only on entry to DONE or on reset.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shift_a, shift_a_nx;
  logic [WIDTH-1:0] shift_b, shift_b_nx;
  logic [WIDTH-1:0] res, res_nx;
  logic             carry, carry_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] sum_nx;
  logic             cout_nx;
  logic             busy_nx, done_nx;
  logic [1:0]       fa_p0;

  // Returns {carry, sum} of a half adder.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Two chained half adders plus an OR on the carries form one full-add bit.
  function automatic logic [1:0] full_add_bit(input logic x, input logic y, input logic c);
    logic [1:0] h1;
    logic [1:0] h2;
    h1 = half_add(x, y);
    h2 = half_add(h1[0], c);
    return {h1[1] | h2[1], h2[0]};
  endfunction

  always_comb begin
    state_nx   = state;
    shift_a_nx = shift_a;
    shift_b_nx = shift_b;
    res_nx     = res;
    carry_nx   = carry;
    cnt_nx     = cnt;
    sum_nx     = sum;
    cout_nx    = cout;
    fa_p0      = full_add_bit(shift_a[0], shift_b[0], carry);

    unique case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (start) begin
          shift_a_nx = a;
          shift_b_nx = b;
          carry_nx   = cin;
          cnt_nx     = '0;
          state_nx   = ADD;
        end
      end
      ADD: begin
        shift_a_nx = shift_a >> 1;
        shift_b_nx = shift_b >> 1;
        res_nx     = (res >> 1) | {fa_p0[0], {(WIDTH-1){1'b0}}};
        carry_nx   = fa_p0[1];
        if (cnt == LAST) begin
          // Final bit: publish the result in the same edge that enters DONE.
          state_nx = DONE;
          sum_nx   = res_nx;
          cout_nx  = fa_p0[1];
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx == ADD);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift_a <= '0;
      shift_b <= '0;
      res     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      shift_a <= shift_a_nx;
      shift_b <= shift_b_nx;
      res     <= res_nx;
      carry   <= carry_nx;
      cnt     <= cnt_nx;
      sum     <= sum_nx;
      cout    <= cout_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial multi-bit adder built around the team's half-adder sum/carry equations: one bit position per clock, LSB first, with a registered carry.
- Sits directly downstream of the half_adder cell. Each cycle it chains two half-adder evaluations plus an OR to form a full-add bit, then folds the carry back through a flip-flop.
- Used where area matters more than latency; provides a start/busy/done handshake to the controlling logic.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, request to begin an addition; sampled only in IDLE or DONE.
- a, input, WIDTH, operand A; captured on the accepting edge.
- b, input, WIDTH, operand B; captured on the accepting edge.
- cin, input, 1, carry-in; captured on the accepting edge.
- busy, output, 1, high while bits are being processed.
- done, output, 1, one-cycle pulse when sum/cout become valid.
- sum, output, WIDTH, result register; holds the last completed result.
- cout, output, 1, carry-out of the last completed result.

Behaviour:
- Reset: on the rising edge of clk with rst_n=0, state goes to IDLE and busy=0, done=0, sum=0, cout=0. All internal shift registers, the carry flop and the bit counter are cleared. Reset has priority over every other event, including reset in the middle of an operation; the partial result is discarded.
- FSM states: IDLE, ADD, DONE.
- IDLE: if start=1, capture a, b and cin into shift_a, shift_b and carry. Clear the bit counter and go to ADD. Otherwise stay in IDLE.
- ADD: each cycle, using bit 0 of shift_a and shift_b with carry c:
  - s1 = a0 XOR b0, c1 = a0 AND b0 (first half adder).
  - s = s1 XOR c, c2 = s1 AND c (second half adder).
  - Next carry = c1 OR c2.
  - shift_a and shift_b shift right by 1.
  - The result shift register shifts right with s inserted at the MSB.
  - The counter increments. When counter = WIDTH-1, go to DONE.
- Entering DONE: sum is loaded from the result shift register (including the final bit), cout is loaded from the final carry, done=1, busy=0.
- DONE lasts exactly one cycle. With start=1 it accepts new operands as in IDLE and goes to ADD; otherwise it returns to IDLE.
- busy = 1 exactly while in ADD (registered). done = 1 exactly while in DONE.
- Latency: start accepted at edge N → busy high from edge N to edge N+WIDTH → done high for the cycle after edge N+WIDTH. WIDTH+1 cycles from the accept edge to the done pulse.
- Throughput: back-to-back operations are possible by asserting start during the DONE cycle, giving one result per WIDTH+1 cycles.
- start while in ADD is ignored. Operand changes during ADD have no effect.
- sum and cout change only on entry to DONE or on reset. They remain stable through IDLE and through the following ADD.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1); no overflow flag.
- Counter width: clog2(WIDTH) bits. It must not wrap before reaching WIDTH-1.

Test Plan:
- Basic add, WIDTH=8: a=8'h5A, b=8'h3C, cin=0, start pulse → done exactly 9 cycles after the accept edge; sum=8'h96, cout=0; busy high for exactly 8 cycles.
- Full carry ripple: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Start ignored while busy: start accepted with a=8'h10, b=8'h20; at cycle 3 pulse start with a=8'hFF, b=8'hFF → single done pulse, sum=8'h30, cout=0; no second operation begins.
- Back-to-back: hold start=1 with a=8'h01, b=8'h01, then change operands to 8'h80+8'h80 during the first DONE cycle → first done gives sum=8'h02, cout=0; second done follows 9 cycles later with sum=8'h00, cout=1. sum holds 8'h02 throughout the second ADD.
- Reset mid-operation: start 8'hAA+8'h55, assert rst_n=0 at cycle 4 for one edge → next cycle busy=0, done=0, sum=0, cout=0, state IDLE; no done pulse follows; a new start afterwards computes correctly.
- Randomised check: 1000 random a/b/cin values, WIDTH=8 and WIDTH=16 → {cout,sum} matches a+b+cin on every done pulse.
